int_sequencer: RTL

Interrupt entry/exit controller for the pipelined processor. On a latched `interrupt` it freezes fetch, drains the pipeline and pushes the return PC and condition flags onto the data-memory stack. It then redirects the PC to the ISR base. On `rti` from the decode stage it pops flags and PC back and resumes. It owns the data-memory port through a req/ack handshake while sequencing.

---
 rtl/int_sequencer.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/int_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : int_sequencer
//  Purpose  : Interrupt entry/exit sequencer. Freezes fetch, drains the pipe,
//             pushes return PC and CCR onto the data-memory stack, vectors to
//             the ISR; on RTI pops them back and resumes.
//  Options  : INT_NESTED_EN - allow up to three nested handlers (depth count)
//  Revision : 1.0 - initial release
// ============================================================================
module int_sequencer #(
    parameter logic [31:0] ISR_ADDR     = 32'h0000_0000,
    parameter int          DRAIN_CYCLES = 3              // must be >= 1
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        interrupt_i,
    input  logic        rti_i,
    input  logic [31:0] pc_next_i,
    input  logic [2:0]  flags_in_i,
    input  logic [31:0] sp_in_i,
    input  logic [15:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        stall_fetch_o,
    output logic        flush_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [15:0] mem_wdata_o,
    output logic        sp_we_o,
    output logic [31:0] sp_out_o,
    output logic        pc_load_o,
    output logic [31:0] pc_value_o,
    output logic        flags_load_o,
    output logic [2:0]  flags_value_o,
    output logic        in_isr_o
);

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_DRAIN   = 4'd1;
    localparam logic [3:0] ST_PUSH_HI = 4'd2;
    localparam logic [3:0] ST_PUSH_LO = 4'd3;
    localparam logic [3:0] ST_PUSH_F  = 4'd4;
    localparam logic [3:0] ST_VECTOR  = 4'd5;
    localparam logic [3:0] ST_POP_F   = 4'd6;
    localparam logic [3:0] ST_POP_LO  = 4'd7;
    localparam logic [3:0] ST_POP_HI  = 4'd8;
    localparam logic [3:0] ST_RESUME  = 4'd9;

    localparam int              CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

    logic [3:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             pending_q, pending_d;
    logic             rti_q,    rti_d;
    logic             flush_q,  flush_d;
    logic [31:0]      ret_pc_q, ret_pc_d;
    logic [31:0]      sp_q,     sp_d;
    logic [2:0]       flg_q,    flg_d;
    logic             in_isr;
    logic             can_take;

`ifdef INT_NESTED_EN
    logic [1:0] depth_q, depth_d;
    assign in_isr   = (depth_q != 2'd0);
    assign can_take = (depth_q != 2'd3);
`else
    logic isr_q, isr_d;
    assign in_isr   = isr_q;
    assign can_take = !isr_q;
`endif

    // Next-state logic: sequencing of entry/exit and stack-pointer updates
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q | interrupt_i;
        rti_d     = 1'b0;
        flush_d   = 1'b0;
        ret_pc_d  = ret_pc_q;
        sp_d      = sp_q;
        flg_d     = flg_q;
`ifdef INT_NESTED_EN
        depth_d   = depth_q;
`else
        isr_d     = isr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rti_q) begin
                    // Pop pre-increments, so start one above the current SP
                    state_d = ST_POP_F;
                    sp_d    = sp_in_i + 32'd1;
                    flush_d = 1'b1;
                end else if (pending_q && can_take && !(rti_i && in_isr)) begin
                    // An RTI arriving this cycle wins; the request waits
                    state_d   = ST_DRAIN;
                    pending_d = 1'b0;
                    cnt_d     = '0;
                    flush_d   = 1'b1;
                    ret_pc_d  = pc_next_i;
                    sp_d      = sp_in_i;
                    flg_d     = flags_in_i;
                end else begin
                    rti_d = rti_i & in_isr;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_PUSH_HI;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PUSH_HI: if (mem_ack_i) begin
                state_d = ST_PUSH_LO;
                sp_d    = sp_q - 32'd1;
            end
            ST_PUSH_LO: if (mem_ack_i) begin
                state_d = ST_PUSH_F;
                sp_d    = sp_q - 32'd1;
            end
            ST_PUSH_F: if (mem_ack_i) begin
                state_d = ST_VECTOR;
                sp_d    = sp_q - 32'd1;
            end
            ST_VECTOR: begin
                state_d = ST_IDLE;
`ifdef INT_NESTED_EN
                depth_d = depth_q + 2'd1;
`else
                isr_d   = 1'b1;
`endif
            end
            ST_POP_F: if (mem_ack_i) begin
                state_d = ST_POP_LO;
                flg_d   = mem_rdata_i[2:0];
                sp_d    = sp_q + 32'd1;
            end
            ST_POP_LO: if (mem_ack_i) begin
                state_d         = ST_POP_HI;
                ret_pc_d[15:0]  = mem_rdata_i;
                sp_d            = sp_q + 32'd1;
            end
            ST_POP_HI: if (mem_ack_i) begin
                // Last pop leaves SP pointing at the slot just read
                state_d         = ST_RESUME;
                ret_pc_d[31:16] = mem_rdata_i;
            end
            ST_RESUME: begin
                state_d = ST_IDLE;
`ifdef INT_NESTED_EN
                depth_d = depth_q - 2'd1;
`else
                isr_d   = 1'b0;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset abandons any sequence in progress
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            rti_q     <= 1'b0;
            flush_q   <= 1'b0;
            ret_pc_q  <= 32'd0;
            sp_q      <= 32'd0;
            flg_q     <= 3'd0;
`ifdef INT_NESTED_EN
            depth_q   <= 2'd0;
`else
            isr_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            rti_q     <= rti_d;
            flush_q   <= flush_d;
            ret_pc_q  <= ret_pc_d;
            sp_q      <= sp_d;
            flg_q     <= flg_d;
`ifdef INT_NESTED_EN
            depth_q   <= depth_d;
`else
            isr_q     <= isr_d;
`endif
        end
    end

    // Outputs decoded from registered state only, so they stay stable across waits
    always_comb begin
        stall_fetch_o = (state_q != ST_IDLE);
        flush_o       = flush_q;
        mem_we_o      = (state_q == ST_PUSH_HI) || (state_q == ST_PUSH_LO) ||
                        (state_q == ST_PUSH_F);
        mem_req_o     = mem_we_o || (state_q == ST_POP_F) || (state_q == ST_POP_LO) ||
                        (state_q == ST_POP_HI);
        mem_addr_o    = mem_req_o ? sp_q : 32'd0;
        case (state_q)
            ST_PUSH_HI: mem_wdata_o = ret_pc_q[31:16];
            ST_PUSH_LO: mem_wdata_o = ret_pc_q[15:0];
            ST_PUSH_F:  mem_wdata_o = {13'd0, flg_q};
            default:    mem_wdata_o = 16'd0;
        endcase
        pc_load_o     = (state_q == ST_VECTOR) || (state_q == ST_RESUME);
        sp_we_o       = pc_load_o;
        sp_out_o      = pc_load_o ? sp_q : 32'd0;
        pc_value_o    = (state_q == ST_VECTOR) ? ISR_ADDR :
                        (state_q == ST_RESUME) ? ret_pc_q : 32'd0;
        flags_load_o  = (state_q == ST_RESUME);
        flags_value_o = flags_load_o ? flg_q : 3'd0;
        in_isr_o      = in_isr;
    end

endmodule
`default_nettype wire
